ir_frame_receiver: RTL and testbench

Front-end IR stage that turns the raw demodulated IR receiver pin into decoded NEC frames. It feeds the scancode path upstream of the IR-to-button decoder. The block synchronizes and glitch-filters the pin, times marks and spaces against a prescaled tick, and validates the 32-bit NEC frame. It outputs an 8-bit command with a one-cycle valid strobe, plus separate repeat and error strobes.

---
 rtl/ir_pkg.sv | 49 ++++
 rtl/ir_frame_receiver_if.sv | 25 ++
 rtl/ir_edge_filter.sv | 77 +++++++
 rtl/ir_frame_receiver.sv | 226 ++++++++++++++++++++++
 tb/tb_ir_frame_receiver.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ir_pkg.sv
// Shared types and NEC timing windows for the IR frame receiver.
// All widths are in sample ticks; one NEC unit (562.5 us) is 8 ticks.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        RPT_MARK
    } ir_state_t;

    // Observation bundle for checkers: FSM state, filtered pin level,
    // current width count and received bit index.
    typedef struct packed {
        ir_state_t  state;
        logic       level;
        logic [7:0] width;
        logic [5:0] bit_idx;
    } ir_debug_t;

    // Leader mark: 9 ms nominal (128 ticks).
    localparam logic [7:0] LEAD_MARK_MIN   = 8'd112;
    localparam logic [7:0] LEAD_MARK_MAX   = 8'd144;
    // Space after the leader of a data frame: 4.5 ms nominal (64 ticks).
    localparam logic [7:0] FRAME_SPACE_MIN = 8'd56;
    localparam logic [7:0] FRAME_SPACE_MAX = 8'd72;
    // Space after the leader of a repeat code: 2.25 ms nominal (32 ticks).
    localparam logic [7:0] RPT_SPACE_MIN   = 8'd28;
    localparam logic [7:0] RPT_SPACE_MAX   = 8'd36;
    // One unit: bit marks, zero spaces and the stop mark (8 ticks).
    localparam logic [7:0] UNIT_MIN        = 8'd5;
    localparam logic [7:0] UNIT_MAX        = 8'd11;
    // Space encoding a one: three units (24 ticks).
    localparam logic [7:0] ONE_SPACE_MIN   = 8'd19;
    localparam logic [7:0] ONE_SPACE_MAX   = 8'd29;
    // Width counter saturation value; reaching it outside IDLE aborts.
    localparam logic [7:0] TIMEOUT_TICKS   = 8'd255;

    localparam logic [5:0] FRAME_BITS      = 6'd32;

    function automatic logic in_window(input logic [7:0] w,
                                       input logic [7:0] lo,
                                       input logic [7:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_frame_receiver_if.sv
// Bundle between the raw IR pin and the decoded-frame consumer.
//
// Handshake: there is no backpressure. valid, repeat_code and error are
// one-cycle strobes, at most one of them high in any cycle; the consumer
// must sample them every clock. value/address are stable from the cycle
// valid rises until the next valid. held is a level.
interface ir_frame_receiver_if;
    logic        ir_signal;
    logic [7:0]  value;
    logic [15:0] address;
    logic        valid;
    logic        repeat_code;
    logic        error;
    logic        held;

    modport master (
        output ir_signal,
        input  value, address, valid, repeat_code, error, held
    );

    modport slave (
        input  ir_signal,
        output value, address, valid, repeat_code, error, held
    );
endinterface

// File: rtl/ir_edge_filter.sv
// Pin conditioning: tick prescaler, 2-FF synchronizer, polarity fix and a
// 3-sample majority-free agreement filter. Both edges are delayed by the
// same 2 ticks, so mark/space widths survive filtering unchanged.
// rise/fall are registered together with level, one cycle after the tick
// that caused the change.
module ir_edge_filter #(
    parameter int unsigned CLKS_PER_TICK = 3516,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic ir_signal,
    output logic tick,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam logic [11:0] PRESC_LAST = 12'(CLKS_PER_TICK - 1);
    localparam logic [1:0]  PIN_IDLE   = {2{ACTIVE_LOW}};

    logic [11:0] presc;
    logic [1:0]  sync;
    logic        mark_now;
    logic [1:0]  hist;
    logic        agree_mark;
    logic        agree_space;

    // Free-running prescaler producing a one-cycle tick every CLKS_PER_TICK clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 12'd1;
        end
    end

    assign tick = (presc == PRESC_LAST);

    // Two-flop synchronizer; resets to the idle pin level so reset never looks like a mark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= PIN_IDLE;
        end else begin
            sync <= {sync[0], ir_signal};
        end
    end

    assign mark_now    = sync[1] ^ ACTIVE_LOW;
    assign agree_mark  = mark_now & hist[0] & hist[1];
    assign agree_space = ~(mark_now | hist[0] | hist[1]);

    // Per-tick sampling: level flips only when three consecutive samples agree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                hist <= {hist[0], mark_now};
                if (agree_mark && !level) begin
                    level <= 1'b1;
                    rise  <= 1'b1;
                end else if (agree_space && level) begin
                    level <= 1'b0;
                    fall  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ir_frame_receiver.sv
// NEC frame receiver: times filtered marks/spaces in ticks, walks the NEC
// leader/bit/stop sequence, checks the command inverse and keeps a hold
// window during which repeat codes are reported.
// CLKS_PER_TICK must be at least 2 so an edge never lands on a tick cycle.
module ir_frame_receiver
    import ir_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = 3516,
    parameter int unsigned HOLD_TICKS    = 2844,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    ir_frame_receiver_if.slave bus,
    output ir_debug_t          debug
);
    localparam logic [11:0] HOLD_LOAD = 12'(HOLD_TICKS);

    logic        tick;
    logic        level;
    logic        rise;
    logic        fall;

    logic [7:0]  width;
    ir_state_t   state;
    ir_state_t   state_n;
    logic [5:0]  bit_idx;
    logic [5:0]  bit_idx_n;
    logic [31:0] shreg;
    logic [31:0] shreg_n;
    logic        do_valid;
    logic        do_repeat;
    logic        do_error;

    logic [11:0] hold_cnt;
    logic        held_q;
    logic        valid_q;
    logic        repeat_q;
    logic        error_q;
    logic [7:0]  value_q;
    logic [15:0] address_q;

    ir_edge_filter #(
        .CLKS_PER_TICK (CLKS_PER_TICK),
        .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ir_signal (bus.ir_signal),
        .tick      (tick),
        .level     (level),
        .rise      (rise),
        .fall      (fall)
    );

    // Ticks since the last filtered edge; at an edge it equals the width just ended.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            width <= '0;
        end else if (rise || fall) begin
            width <= '0;
        end else if (tick && (width != TIMEOUT_TICKS)) begin
            width <= width + 8'd1;
        end
    end

    // FSM state, bit index and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    // Next-state decode: mark ends are falls, space ends are rises.
    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        do_valid  = 1'b0;
        do_repeat = 1'b0;
        do_error  = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = LEAD_MARK;
                end
            end
            LEAD_MARK: begin
                if (fall) begin
                    if (in_window(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                        state_n = LEAD_SPACE;
                    end else begin
                        do_error = 1'b1;
                        state_n  = IDLE;
                    end
                end
            end
            LEAD_SPACE: begin
                if (rise) begin
                    if (in_window(width, FRAME_SPACE_MIN, FRAME_SPACE_MAX)) begin
                        bit_idx_n = '0;
                        state_n   = BIT_MARK;
                    end else if (in_window(width, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                        state_n = RPT_MARK;
                    end else begin
                        do_error = 1'b1;
                        state_n  = IDLE;
                    end
                end
            end
            BIT_MARK: begin
                if (fall) begin
                    if (!in_window(width, UNIT_MIN, UNIT_MAX)) begin
                        do_error = 1'b1;
                        state_n  = IDLE;
                    end else if (bit_idx == FRAME_BITS) begin
                        // Stop mark: command byte must match its inverse.
                        if (shreg[23:16] == ~shreg[31:24]) begin
                            do_valid = 1'b1;
                        end else begin
                            do_error = 1'b1;
                        end
                        state_n = IDLE;
                    end else begin
                        state_n = BIT_SPACE;
                    end
                end
            end
            BIT_SPACE: begin
                if (rise) begin
                    if (in_window(width, UNIT_MIN, UNIT_MAX)) begin
                        shreg_n   = {1'b0, shreg[31:1]};
                        bit_idx_n = bit_idx + 6'd1;
                        state_n   = BIT_MARK;
                    end else if (in_window(width, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                        shreg_n   = {1'b1, shreg[31:1]};
                        bit_idx_n = bit_idx + 6'd1;
                        state_n   = BIT_MARK;
                    end else begin
                        do_error = 1'b1;
                        state_n  = IDLE;
                    end
                end
            end
            RPT_MARK: begin
                if (fall) begin
                    // A repeat with nothing held is dropped without complaint.
                    if (in_window(width, UNIT_MIN, UNIT_MAX)) begin
                        do_repeat = held_q;
                    end else begin
                        do_error = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A level that never ends aborts the frame.
        if ((state != IDLE) && (width == TIMEOUT_TICKS) && !rise && !fall) begin
            do_valid  = 1'b0;
            do_repeat = 1'b0;
            do_error  = 1'b1;
            state_n   = IDLE;
        end
    end

    // Hold window: reloaded by a valid frame or honoured repeat, counts down per tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q   <= 1'b0;
            hold_cnt <= '0;
        end else if (do_valid || do_repeat) begin
            held_q   <= 1'b1;
            hold_cnt <= HOLD_LOAD;
        end else if (tick && held_q) begin
            if (hold_cnt <= 12'd1) begin
                held_q   <= 1'b0;
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt - 12'd1;
            end
        end
    end

    // Registered strobes and the last accepted command/address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            repeat_q  <= 1'b0;
            error_q   <= 1'b0;
            value_q   <= '0;
            address_q <= '0;
        end else begin
            valid_q  <= do_valid;
            repeat_q <= do_repeat;
            error_q  <= do_error;
            if (do_valid) begin
                value_q   <= shreg[23:16];
                address_q <= shreg[15:0];
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.address     = address_q;
    assign bus.valid       = valid_q;
    assign bus.repeat_code = repeat_q;
    assign bus.error       = error_q;
    assign bus.held        = held_q;

    assign debug.state   = state;
    assign debug.level   = level;
    assign debug.width   = width;
    assign debug.bit_idx = bit_idx;

endmodule

// File: tb/tb_ir_frame_receiver.sv
// Bench for ir_frame_receiver: NEC pulse trains described as lists of
// mark/space widths in ticks, decoded by a list-walking reference model.
module tb_ir_frame_receiver;
  import ir_pkg::*;

  localparam int unsigned CPT     = 3;
  localparam int unsigned HOLD    = 800;
  localparam bit          ACT_LOW = 1'b1;
  localparam int W      = 26;
  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_RPT   = 2;
  localparam int K_ERR   = 3;

  // ---------------- clock / reset / DUT ----------------
  logic      clk = 1'b0;
  logic      reset;
  ir_debug_t dbg;

  ir_frame_receiver_if bus ();

  ir_frame_receiver #(
    .CLKS_PER_TICK (CPT),
    .HOLD_TICKS    (HOLD),
    .ACTIVE_LOW    (ACT_LOW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .debug (dbg)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int           seg_q[$];
  logic [7:0]   exp_value;
  logic [15:0]  exp_address;
  longint       t_now;
  longint       t_reload;
  bit           have_hold;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every strobe is matched against the head of the expected queue.
  always @(negedge clk) begin
    logic [1:0]   k;
    logic [W-1:0] got;
    if (!reset && (bus.valid || bus.repeat_code || bus.error)) begin
      check_eq("strobe_excl", $countones({bus.valid, bus.repeat_code, bus.error}), 1);
      k   = bus.valid ? 2'(K_VALID) : (bus.repeat_code ? 2'(K_RPT) : 2'(K_ERR));
      got = {k, bus.address, bus.value};
      if (exp_q.size() == 0) check_eq("unexpected_evt", got, 0);
      else check_eq("evt", got, exp_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  function automatic bit win(input int w, input int lo, input int hi);
    return (w >= lo) && (w <= hi);
  endfunction

  // Past the end of the list the pin idles in space forever.
  function automatic int seg(input int i);
    return (i < seg_q.size()) ? seg_q[i] : 100000;
  endfunction

  function automatic int nec_model(input bit is_held, output logic [31:0] bits);
    bits = '0;
    if (!win(seg(0), 112, 144)) return K_ERR;
    if (win(seg(1), 28, 36)) return win(seg(2), 5, 11) ? (is_held ? K_RPT : K_NONE) : K_ERR;
    if (!win(seg(1), 56, 72)) return K_ERR;
    for (int i = 0; i < 32; i++) begin
      if (!win(seg(2 + 2 * i), 5, 11)) return K_ERR;
      if (win(seg(3 + 2 * i), 19, 29)) bits[i] = 1'b1;
      else if (!win(seg(3 + 2 * i), 5, 11)) return K_ERR;
    end
    if (!win(seg(66), 5, 11)) return K_ERR;
    return (bits[23:16] == ~bits[31:24]) ? K_VALID : K_ERR;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit mark, input int ticks);
    bus.ir_signal = ACT_LOW ? ~mark : mark;
    repeat (ticks * CPT) @(negedge clk);
    t_now += ticks;
  endtask

  task automatic idle(input int ticks, input int glen);
    if (glen > 0) begin
      drive(1'b0, 20);
      drive(1'b1, glen);
      drive(1'b0, ticks - 20 - glen);
    end else begin
      drive(1'b0, ticks);
    end
  endtask

  task automatic send_segs(input int glitch_at, input int glen);
    for (int i = 0; i < seg_q.size(); i++) begin
      if ((i % 2 == 1) && (i == glitch_at)) begin
        drive(1'b0, 3);
        drive(1'b1, glen);
        drive(1'b0, seg_q[i] - 3 - glen);
      end else begin
        drive((i % 2) == 0, seg_q[i]);
      end
    end
  endtask

  task automatic build_frame(input logic [31:0] bits, input int lm, input int ls,
                             input int mk, input int z, input int o, input int sp);
    seg_q = {};
    seg_q.push_back(lm);
    seg_q.push_back(ls);
    for (int i = 0; i < 32; i++) begin
      seg_q.push_back(mk);
      seg_q.push_back(bits[i] ? o : z);
    end
    seg_q.push_back(sp);
  endtask

  function automatic logic [31:0] nec_bits(input logic [15:0] addr, input logic [7:0] cmd,
                                           input logic [7:0] inv);
    return {inv, cmd, addr};
  endfunction

  task automatic run_seq(input int pre_idle, input int idle_glen, input int glitch_at,
                         input int glen);
    logic [31:0] bits;
    int          kind;
    longint      t_end;
    t_end = t_now + pre_idle;
    foreach (seg_q[i]) t_end += seg_q[i];
    kind = nec_model(have_hold && ((t_end - t_reload) < HOLD), bits);
    if (kind == K_VALID) begin
      exp_value   = bits[23:16];
      exp_address = bits[15:0];
    end
    if (kind != K_NONE) exp_q.push_back({2'(kind), exp_address, exp_value});
    if (kind == K_VALID || kind == K_RPT) begin
      have_hold = 1'b1;
      t_reload  = t_end;
    end
    idle(pre_idle, idle_glen);
    send_segs(glitch_at, glen);
    drive(1'b0, 30);
    check_eq("missing_evt", exp_q.size(), 0);
  endtask

  task automatic check_held();
    longint d;
    d = t_now - t_reload;
    if (!have_hold || d > HOLD + 10) check_eq("held_low", bus.held, 1'b0);
    else if (d < HOLD - 10) check_eq("held_high", bus.held, 1'b1);
  endtask

  task automatic send_random_frame();
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic [7:0]  inv;
    addr = 16'($urandom);
    cmd  = 8'($urandom);
    inv  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~cmd;
    build_frame(nec_bits(addr, cmd, inv), $urandom_range(112, 144), $urandom_range(56, 72),
                $urandom_range(5, 11), $urandom_range(5, 11), $urandom_range(19, 29),
                $urandom_range(5, 11));
    run_seq(40, 0, -1, 0);
    check_held();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    bus.ir_signal = ACT_LOW;
    exp_value     = '0;
    exp_address   = '0;
    t_now         = 0;
    t_reload      = 0;
    have_hold     = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_value", bus.value, 8'h00);
    check_eq("rst_address", bus.address, 16'h0000);
    check_eq("rst_valid", bus.valid, 1'b0);
    check_eq("rst_repeat", bus.repeat_code, 1'b0);
    check_eq("rst_error", bus.error, 1'b0);
    check_eq("rst_held", bus.held, 1'b0);
    check_eq("rst_fsm", dbg.state, IDLE);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal frame: address 0x00/0xFF, command 0x45/0xBA.
    build_frame(nec_bits(16'hFF00, 8'h45, 8'hBA), 128, 64, 8, 8, 24, 8);
    run_seq(40, 0, -1, 0);
    check_eq("nominal_value", bus.value, 8'h45);
    check_eq("nominal_address", bus.address, 16'hFF00);
    check_held();

    // Repeat inside the hold window, then one long after it expired.
    seg_q = {128, 32, 8};
    run_seq(300, 0, -1, 0);
    check_eq("rpt_value", bus.value, 8'h45);
    seg_q = {128, 32, 8};
    run_seq(1200, 0, -1, 0);
    check_held();

    // Inverse mismatch keeps the previous command.
    build_frame(nec_bits(16'h1234, 8'h45, 8'h00), 128, 64, 8, 8, 24, 8);
    run_seq(40, 0, -1, 0);
    check_eq("badinv_value", bus.value, 8'h45);

    // Short glitches in idle and inside a bit space.
    build_frame(nec_bits(16'($urandom), 8'h3C, 8'hC3), 128, 64, 8, 8, 24, 8);
    run_seq(40, 1, 13, 2);
    build_frame(nec_bits(16'($urandom), 8'h5A, 8'hA5), 128, 64, 8, 8, 24, 8);
    run_seq(40, 2, 7, 1);

    // Tolerance edges.
    build_frame(nec_bits(16'hA55A, 8'h81, 8'h7E), 112, 56, 5, 5, 19, 5);
    run_seq(40, 0, -1, 0);
    build_frame(nec_bits(16'h0F0F, 8'h24, 8'hDB), 144, 72, 11, 11, 29, 11);
    run_seq(40, 0, -1, 0);

    // Out-of-window widths, long bit space and a stuck mark.
    seg_q = {111};
    run_seq(40, 0, -1, 0);
    seg_q = {145};
    run_seq(40, 0, -1, 0);
    seg_q = {128, 64, 8, 30, 8};
    run_seq(40, 0, -1, 0);
    seg_q = {128, 64, 8, 40, 8};
    run_seq(40, 0, -1, 0);
    check_eq("space40_fsm", dbg.state, IDLE);
    seg_q = {284};
    run_seq(40, 0, -1, 0);
    check_eq("stuck_fsm", dbg.state, IDLE);
    build_frame(nec_bits(16'hBEEF, 8'h99, 8'h66), 128, 64, 8, 8, 24, 8);
    run_seq(40, 0, -1, 0);
    check_eq("recover_value", bus.value, 8'h99);

    // Reset during bit 17.
    build_frame(nec_bits(16'hCAFE, 8'h77, 8'h88), 128, 64, 8, 8, 24, 8);
    while (seg_q.size() > 37) void'(seg_q.pop_back());
    idle(40, 0);
    send_segs(-1, 0);
    drive(1'b0, 3);
    reset = 1'b1;
    #1;
    check_eq("midrst_value", bus.value, 8'h00);
    check_eq("midrst_address", bus.address, 16'h0000);
    check_eq("midrst_held", bus.held, 1'b0);
    check_eq("midrst_strobes", {bus.valid, bus.repeat_code, bus.error}, 3'b000);
    check_eq("midrst_fsm", dbg.state, IDLE);
    exp_value   = '0;
    exp_address = '0;
    have_hold   = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    build_frame(nec_bits(16'h00F7, 8'h16, 8'hE9), 128, 64, 8, 8, 24, 8);
    run_seq(40, 0, -1, 0);
    check_eq("post_rst_value", bus.value, 8'h16);
    check_held();

    // Randomized frames with random in-window widths.
    for (int n = 0; n < 4; n++) send_random_frame();

    check_eq("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
